seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits downstream of the display-word selector, which produces a 16-bit word of four 4-bit glyph codes from the game state. The driver snapshots that word once per scan frame so a frame never shows a torn word. It decodes each nibble to segments, scans the digits left to right and applies per-digit blinking.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 9 +
 rtl/seg7_scan_driver.sv | 79 +++++++
 tb/tb_seg7_scan_driver.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph codes and active-high segment ROM shared by the display-word selector and the scan driver.
package seg7_pkg;
    localparam logic [3:0] GLYPH_A     = 4'hA;
    localparam logic [3:0] GLYPH_B     = 4'hB;
    localparam logic [3:0] GLYPH_C     = 4'hC;
    localparam logic [3:0] GLYPH_D     = 4'hD;
    localparam logic [3:0] GLYPH_E     = 4'hE;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Bit order {g,f,e,d,c,b,a}, 1 = segment on.
    function automatic logic [6:0] glyph_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:        return 7'h3F;
            4'h1:        return 7'h06;
            4'h2:        return 7'h5B;
            4'h3:        return 7'h4F;
            4'h4:        return 7'h66;
            4'h5:        return 7'h6D;
            4'h6:        return 7'h7D;
            4'h7:        return 7'h07;
            4'h8:        return 7'h7F;
            4'h9:        return 7'h6F;
            GLYPH_A:     return 7'h77;
            GLYPH_B:     return 7'h7C;
            GLYPH_C:     return 7'h39;
            GLYPH_D:     return 7'h5E;
            GLYPH_E:     return 7'h79;
            GLYPH_BLANK: return 7'h00;
            default:     return 7'h00;
        endcase
    endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational glyph code to active-low segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] glyph_i,
    output logic [6:0] seg_o
);
    assign seg_o = ~glyph_to_seg(glyph_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode scan with per-frame word snapshot, ghost guard and per-digit blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_in,
    input  logic [3:0]  blink_mask,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [15:0]   word_q, word_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d, dec_seg;
    logic          done_q;
    logic          slot_end, frame_end, blink_end, lit;

    seg7_decode u_decode (
        .glyph_i(word_q[{idx_q, 2'b00} +: 4]),
        .seg_o  (dec_seg)
    );

    always_comb begin
        slot_end  = cnt_q == CW'(DIGIT_CYCLES - 1);
        frame_end = slot_end && idx_q == 2'd0;
        blink_end = bcnt_q == BW'(BLINK_FRAMES - 1);
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = slot_end ? idx_q - 2'd1 : idx_q;
        bcnt_d    = frame_end ? (blink_end ? '0 : bcnt_q + BW'(1)) : bcnt_q;
        phase_d   = phase_q ^ (frame_end && blink_end);
        word_d    = frame_end ? data_in : word_q;
        mask_d    = frame_end ? blink_mask : mask_q;
        // The last cycle of each slot is dark so idx can move without ghosting.
        lit       = enable && !slot_end && !(mask_q[idx_q] && phase_q);
        an_d      = lit ? ~(4'b0001 << idx_q) : 4'hF;
        seg_d     = lit ? dec_seg : 7'h7F;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            word_q  <= 16'hFFFF;
            mask_q  <= 4'h0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            done_q  <= frame_end;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench with a position-based reference model of the scan driver.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_in = 16'h1A1F;
    logic [3:0]  blink_mask = 4'h0;
    logic        enable = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGIT_CYCLES(4), .BLINK_FRAMES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .blink_mask(blink_mask),
        .enable    (enable),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       done;
    } exp_t;

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg_hi;
    } gvec_t;

    exp_t        sbq[$];
    gvec_t       tbl[16];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          dones = 0;
    logic [15:0] m_word = 16'hFFFF;
    logic [3:0]  m_mask = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model is indexed by cycles since reset release: slot = c%4, idx = 3-(c/4)%4, blink phase = (c/32)%2.
    task automatic step();
        int         s;
        int         i;
        int         ph;
        logic       lit;
        logic [3:0] code;
        exp_t       e;
        s    = cyc % 4;
        i    = 3 - (cyc / 4) % 4;
        ph   = (cyc / 32) % 2;
        lit  = enable && s != 3 && !(m_mask[i] && ph == 1);
        code = m_word[i*4 +: 4];
        e.an   = lit ? 4'b1111 ^ (4'b0001 << i) : 4'hF;
        e.seg  = lit ? ~tbl[code].seg_hi : 7'h7F;
        e.done = cyc % 16 == 15;
        sbq.push_back(e);
        if (cyc % 16 == 15) begin
            m_word = data_in;
            m_mask = blink_mask;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        e = sbq.pop_front();
        check("scan_out", {an, seg, frame_done}, {e.an, e.seg, e.done});
        if (frame_done) dones++;
    endtask

    initial begin
        tbl = '{'{4'h0, 7'h3F}, '{4'h1, 7'h06}, '{4'h2, 7'h5B}, '{4'h3, 7'h4F},
                '{4'h4, 7'h66}, '{4'h5, 7'h6D}, '{4'h6, 7'h7D}, '{4'h7, 7'h07},
                '{4'h8, 7'h7F}, '{4'h9, 7'h6F}, '{4'hA, 7'h77}, '{4'hB, 7'h7C},
                '{4'hC, 7'h39}, '{4'hD, 7'h5E}, '{4'hE, 7'h79}, '{4'hF, 7'h00}};
        #12;
        check("reset_out", {an, seg, frame_done}, {4'hF, 7'h7F, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        check("post_release_out", {an, seg}, {4'hF, 7'h7F});
        repeat (32) step();
        dones = 0;
        repeat (16) step();
        check("frame_done_count", dones, 1);

        data_in = 16'h1234;
        repeat (16) step();
        repeat (5) step();
        data_in = 16'h5678;
        repeat (11) step();
        repeat (16) step();

        data_in    = 16'h0000;
        blink_mask = 4'b0001;
        repeat (96) step();

        blink_mask = 4'h0;
        for (int k = 0; k < 16; k++) begin
            data_in = {12'h000, tbl[k].code};
            repeat (16) step();
            repeat (13) step();
            check("decode_digit0", {an, seg}, {4'b1110, ~tbl[k].seg_hi});
            repeat (3) step();
        end

        repeat (5) step();
        enable = 1'b0;
        step();
        check("enable_off_an", an, 4'hF);
        repeat (2) step();
        enable = 1'b1;
        repeat (8) step();

        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_out", {an, seg, frame_done}, {4'hF, 7'h7F, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
        m_word  = 16'hFFFF;
        m_mask  = 4'h0;
        step();
        check("restart_idx3_an", an, 4'b0111);
        repeat (19) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
